// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter and instruction-fetch sequencer.
// Fetches one instruction from a single-beat memory port, holds it for the
// decoder until accepted, then redirects the pc from the decoder's control
// inputs (fallthrough, branch, jump, jump-register). Halts on exception.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to halt on a redirect to
// a non-word-aligned address instead of fetching from it.
module pc_fetch_unit (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_accept,
    input  logic [1:0]  control_type,
    input  logic        except,
    input  logic [15:0] branch_offset,
    input  logic [25:0] jump_target,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic        halted,
    output logic        misaligned
);

    localparam int unsigned XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0040_0000;

    localparam logic [1:0] CT_FALL = 2'b00;
    localparam logic [1:0] CT_BR   = 2'b01;
    localparam logic [1:0] CT_J    = 2'b10;
    localparam logic [1:0] CT_JR   = 2'b11;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inst_q;
    logic            inst_valid_q;
    logic            imem_req_q;
    logic            halted_q;

    logic [XLEN-1:0] pc4_d;
    logic [XLEN-1:0] br_off_d;
    logic [XLEN-1:0] next_pc_d;

    // Redirect target selection; all additions wrap modulo 2^32.
    always_comb begin
        pc4_d     = pc_q + XLEN'(4);
        br_off_d  = {{14{branch_offset[15]}}, branch_offset, 2'b00};
        next_pc_d = pc4_d;
        case (control_type)
            CT_FALL: next_pc_d = pc4_d;
            CT_BR:   next_pc_d = pc4_d + br_off_d;
            CT_J:    next_pc_d = {pc4_d[31:28], jump_target, 2'b00};
            CT_JR:   next_pc_d = jr_target;
            default: next_pc_d = pc4_d;
        endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_q;
    logic misalign_d;

    // A redirect that is not word aligned becomes a halt instead of a fetch.
    always_comb begin
        misalign_d = (next_pc_d[1:0] != 2'b00);
    end

    // Sticky misalignment flag, set only when the halt is caused by it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else if (state_q == S_ISSUE && inst_accept && !except && misalign_d) begin
            misaligned_q <= 1'b1;
        end
    end

    assign misaligned = misaligned_q;
`else
    logic misalign_d;

    // Low address bits pass straight through to the memory port.
    always_comb begin
        misalign_d = 1'b0;
    end

    assign misaligned = 1'b0;
`endif

    // Fetch/issue/halt sequencer with registered outputs.
    // The first FETCH cycle after reset only raises imem_req, so an ack
    // still asserted from the reset period is never captured.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (imem_ack) begin
                        inst_q       <= imem_data;
                        inst_valid_q <= 1'b1;
                        imem_req_q   <= 1'b0;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (inst_accept) begin
                        inst_valid_q <= 1'b0;
                        if (except || misalign_d) begin
                            halted_q   <= 1'b1;
                            imem_req_q <= 1'b0;
                            state_q    <= S_HALT;
                        end else begin
                            pc_q       <= next_pc_d;
                            imem_req_q <= 1'b1;
                            state_q    <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    halted_q     <= 1'b1;
                    imem_req_q   <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
                default: begin
                    halted_q     <= 1'b1;
                    imem_req_q   <= 1'b0;
                    inst_valid_q <= 1'b0;
                    state_q      <= S_HALT;
                end
            endcase
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign pc         = pc_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, branch, jump, jr,
// issue stall, exception halt, async reset and misaligned redirect.
module tb_pc_fetch_unit;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_accept;
    logic [1:0]  control_type;
    logic        except;
    logic [15:0] branch_offset;
    logic [25:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic        halted;
    logic        misaligned;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    pc_fetch_unit dut (
        .clock         (clock),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .inst_accept   (inst_accept),
        .control_type  (control_type),
        .except        (except),
        .branch_offset (branch_offset),
        .jump_target   (jump_target),
        .jr_target     (jr_target),
        .pc            (pc),
        .halted        (halted),
        .misaligned    (misaligned)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One capture edge in FETCH: instruction held, request dropped.
    task automatic do_fetch(input logic [31:0] data, input logic [31:0] cur_pc);
        imem_ack  = 1'b1;
        imem_data = data;
        tick();
        chk("fetch_valid", 32'(inst_valid), 32'd1);
        chk("fetch_inst",  inst,            data);
        chk("fetch_req",   32'(imem_req),   32'd0);
        chk("fetch_pc",    pc,              cur_pc);
    endtask

    // One accept edge in ISSUE with the current control inputs.
    task automatic do_accept(input logic [31:0] nxt_pc);
        inst_accept = 1'b1;
        tick();
        chk("acc_valid", 32'(inst_valid), 32'd0);
        chk("acc_req",   32'(imem_req),   32'd1);
        chk("acc_addr",  imem_addr,       nxt_pc);
        chk("acc_halt",  32'(halted),     32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        imem_ack      = 1'b1;
        imem_data     = 32'hCAFE_0000;
        inst_accept   = 1'b0;
        control_type  = 2'b00;
        except        = 1'b0;
        branch_offset = 16'h0000;
        jump_target   = 26'h0;
        jr_target     = 32'h0;

        // Reset state, with ack asserted throughout reset
        tick(); tick(); tick();
        chk("rst_pc",    pc,               32'h0040_0000);
        chk("rst_req",   32'(imem_req),    32'd0);
        chk("rst_valid", 32'(inst_valid),  32'd0);
        chk("rst_inst",  inst,             32'h0);
        chk("rst_halt",  32'(halted),      32'd0);
        chk("rst_mis",   32'(misaligned),  32'd0);

        // First cycle after release raises the request, nothing captured yet
        reset = 1'b0;
        tick();
        chk("post_rst_req",   32'(imem_req),   32'd1);
        chk("post_rst_addr",  imem_addr,       32'h0040_0000);
        chk("post_rst_valid", 32'(inst_valid), 32'd0);

        // accept while nothing valid is ignored; memory waits two cycles
        imem_ack     = 1'b0;
        inst_accept  = 1'b1;
        control_type = 2'b11;
        jr_target    = 32'h1234_5678;
        tick(); tick();
        chk("noval_pc",    pc,              32'h0040_0000);
        chk("noval_req",   32'(imem_req),   32'd1);
        chk("noval_valid", 32'(inst_valid), 32'd0);
        control_type = 2'b00;

        // Sequential fetch with zero-wait memory
        do_fetch(32'hA000_0000, 32'h0040_0000); do_accept(32'h0040_0004);
        do_fetch(32'hA000_0001, 32'h0040_0004); do_accept(32'h0040_0008);
        do_fetch(32'hA000_0002, 32'h0040_0008); do_accept(32'h0040_000C);
        do_fetch(32'hA000_0003, 32'h0040_000C); do_accept(32'h0040_0010);

        // Backward branch: 0x00400014 + (-2 << 2) = 0x0040000C
        do_fetch(32'hB000_0000, 32'h0040_0010);
        control_type  = 2'b01;
        branch_offset = 16'hFFFE;
        do_accept(32'h0040_000C);
        control_type  = 2'b00;

        do_fetch(32'hA000_0010, 32'h0040_000C); do_accept(32'h0040_0010);
        do_fetch(32'hA000_0011, 32'h0040_0010); do_accept(32'h0040_0014);
        do_fetch(32'hA000_0012, 32'h0040_0014); do_accept(32'h0040_0018);
        do_fetch(32'hA000_0013, 32'h0040_0018); do_accept(32'h0040_001C);

        // Issue stall for 5 cycles; acks and redirect inputs must be ignored
        do_fetch(32'hD00D_F00D, 32'h0040_001C);
        inst_accept  = 1'b0;
        control_type = 2'b11;
        jr_target    = 32'hDEAD_BEE0;
        imem_data    = 32'h5555_AAAA;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_inst",  inst,            32'hD00D_F00D);
            chk("stall_pc",    pc,              32'h0040_001C);
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_req",   32'(imem_req),   32'd0);
        end

        // Jump: {pc4[31:28], 26'h0100008, 2'b00} = 0x00400020
        control_type = 2'b10;
        jump_target  = 26'h0100008;
        do_accept(32'h0040_0020);

        // Jump register to 0x00400100
        do_fetch(32'hE000_0000, 32'h0040_0020);
        control_type = 2'b11;
        jr_target    = 32'h0040_0100;
        do_accept(32'h0040_0100);

        // Exception dominates a jump; unit freezes
        do_fetch(32'hFFFF_FFFF, 32'h0040_0100);
        control_type = 2'b10;
        except       = 1'b1;
        inst_accept  = 1'b1;
        tick();
        chk("exc_halt",  32'(halted),     32'd1);
        chk("exc_pc",    pc,              32'h0040_0100);
        chk("exc_valid", 32'(inst_valid), 32'd0);
        chk("exc_req",   32'(imem_req),   32'd0);
        chk("exc_mis",   32'(misaligned), 32'd0);
        except = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_pc",  pc,            32'h0040_0100);
        end
        chk("halt_hold", 32'(halted), 32'd1);

        // Asynchronous reset pulse between edges
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pc",    pc,              32'h0040_0000);
        chk("arst_halt",  32'(halted),     32'd0);
        chk("arst_valid", 32'(inst_valid), 32'd0);
        chk("arst_req",   32'(imem_req),   32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("rel_req",   32'(imem_req),   32'd1);
        chk("rel_valid", 32'(inst_valid), 32'd0);

        // Misaligned jump-register target
        do_fetch(32'h1234_0000, 32'h0040_0000);
        control_type = 2'b11;
        jr_target    = 32'h0040_0102;
`ifdef FETCH_MISALIGN_TRAP_EN
        inst_accept = 1'b1;
        tick();
        chk("mis_halt", 32'(halted),     32'd1);
        chk("mis_flag", 32'(misaligned), 32'd1);
        chk("mis_pc",   pc,              32'h0040_0000);
        chk("mis_req",  32'(imem_req),   32'd0);
`else
        do_accept(32'h0040_0102);
        chk("mis_flag", 32'(misaligned), 32'd0);
        chk("mis_pc",   pc,              32'h0040_0102);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL use clock and reset as follows: one clock; reset is asynchronous and active-high.
REQ-002 SHALL provide port: clock  in  1  sole clock, rising edge.
REQ-003 SHALL provide port: reset  in  1  async active-high reset.
REQ-004 SHALL provide port: imem_req  out  1  instruction memory read request.
REQ-005 SHALL provide port: imem_addr  out  32  byte address of requested instruction (equals pc).
REQ-006 SHALL provide port: imem_ack  in  1  memory returns imem_data this cycle.
REQ-007 SHALL provide port: imem_data  in  32  instruction word.
REQ-008 SHALL provide port: inst  out  32  held instruction presented to decoder.
REQ-009 SHALL provide port: inst_valid  out  1  inst is valid and awaiting acceptance.
REQ-010 SHALL provide port: inst_accept  in  1  decoder/execute consumes inst this cycle.
REQ-011 SHALL provide port: control_type  in  2  decoder redirect: 00 fallthrough, 01 branch, 10 jump, 11 jump register.
REQ-012 SHALL provide port: except  in  1  decoder reports unrecognised instruction.
REQ-013 SHALL provide port: branch_offset  in  16  inst[15:0] signed word offset.
REQ-014 SHALL provide port: jump_target  in  26  inst[25:0].
REQ-015 SHALL provide port: jr_target  in  32  rs register value.
REQ-016 SHALL provide port: pc  out  32  address of current instruction.
REQ-017 SHALL provide port: halted  out  1  unit stopped on exception.
REQ-018 SHALL provide port: misaligned  out  1  halt caused by misaligned redirect (see Configuration).

Function
REQ-019 SHALL implement states FETCH, ISSUE, HALT; all outputs registered except imem_addr (= pc).
REQ-020 SHALL in FETCH drive imem_req=1, inst_valid=0; on imem_ack=1 capture imem_data into inst, go ISSUE (inst_valid=1, imem_req=0 next cycle).
REQ-021 SHALL accept imem_ack in the same cycle imem_req rises (zero-wait memory: one instruction per 2 cycles minimum).
REQ-022 SHALL ignore imem_ack outside FETCH.
REQ-023 SHALL in ISSUE hold inst and pc stable until inst_accept=1; control_type, except and target inputs are sampled only on that edge.
REQ-024 SHALL on accept with except=0 load pc with next_pc, go FETCH.
REQ-025 SHALL compute pc4 = pc+4; next_pc: 00 -> pc4; 01 -> pc4 + (sign-extended branch_offset << 2); 10 -> {pc4[31:28], jump_target, 2'b00}; 11 -> jr_target; all arithmetic modulo 2^32 (wrap, no trap).
REQ-026 SHALL on accept with except=1 go HALT, leave pc unchanged, clear inst_valid; except dominates any control_type.
REQ-027 SHALL in HALT hold halted=1, imem_req=0, inst_valid=0, pc frozen; exit only via reset.
REQ-028 SHALL ignore inst_accept when inst_valid=0.

Reset
REQ-029 SHALL on reset assertion, at any time including mid-fetch, immediately force: pc=32'h00400000, state FETCH, imem_req=0, inst=0, inst_valid=0, halted=0, misaligned=0.
REQ-030 SHALL assert imem_req in the first cycle after reset deassertion; an imem_ack arriving during reset is discarded.

Configuration
REQ-031 SHALL, with FETCH_MISALIGN_TRAP_EN defined, treat accept with except=0 and next_pc[1:0]!=0 as halt: go HALT, pc unchanged, halted=1, misaligned=1.
REQ-032 SHALL, without FETCH_MISALIGN_TRAP_EN, load next_pc unchanged (low bits passed to imem_addr) and tie misaligned to 0.

Verification
REQ-033 Reset release, imem_ack=1 every cycle, inst_accept=1, control_type=00 -> imem_addr 0x00400000, 0x00400004, 0x00400008 on successive FETCH cycles, inst_valid every other cycle.
REQ-034 pc=0x00400010, control_type=01, branch_offset=16'hFFFE -> next imem_addr 0x0040000C.
REQ-035 pc=0x0040001C, control_type=10, jump_target=26'h0100008 -> next imem_addr 0x00400020; control_type=11, jr_target=0x00400100 -> 0x00400100.
REQ-036 inst_accept held 0 for 5 cycles in ISSUE -> inst, pc, inst_valid=1 unchanged; imem_req=0 throughout.
REQ-037 except=1 with control_type=10 at accept -> halted=1 next cycle, pc unchanged, imem_req stays 0 for 10 cycles; reset pulse -> pc=0x00400000, halted=0.
REQ-038 With FETCH_MISALIGN_TRAP_EN, control_type=11, jr_target=0x00400102 -> halted=1, misaligned=1; without macro -> imem_addr=0x00400102, misaligned=0.
